regfile_writeback: RTL and testbench



---
 rtl/regfile_writeback_if.sv | 40 ++++
 rtl/regfile_writeback.sv | 128 ++++++++++++
 tb/tb_regfile_writeback.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// Handshake and write-port bundle between the issue/ALU/load side and regfile_writeback.
interface regfile_writeback_if #(
    parameter int BITS   = 16,
    parameter int ADDR   = 2,
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic                 issue_valid;
    logic [ADDR-1:0]      issue_addr;
    logic                 alu_valid;
    logic                 alu_ready;
    logic [ADDR-1:0]      alu_addr;
    logic [BITS-1:0]      alu_data;
    logic                 ld_valid;
    logic                 ld_ready;
    logic [ADDR-1:0]      ld_addr;
    logic [BITS-1:0]      ld_data;
    logic                 Write;
    logic [ADDR-1:0]      DestAddr;
    logic [BITS-1:0]      DestData;
    logic [(1<<ADDR)-1:0] busy;
    logic [CW-1:0]        fifo_count;

    modport master (
        output issue_valid, issue_addr,
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        input  alu_ready, ld_ready,
        input  Write, DestAddr, DestData, busy, fifo_count
    );

    modport slave (
        input  issue_valid, issue_addr,
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        output alu_ready, ld_ready,
        output Write, DestAddr, DestData, busy, fifo_count
    );
endinterface

// File: rtl/regfile_writeback.sv
// Arbitrates ALU results and FIFO-buffered load results onto the register-file write port, with a pending-write scoreboard.
// Latency: ALU 1 cycle, load 2 cycles uncontended; ld_ready drops when the FIFO is full, alu_ready drops for one cycle after STARVE ALU wins over a non-empty FIFO.
module regfile_writeback #(
    parameter int BITS   = 16,
    parameter int ADDR   = 2,
    parameter int QDEPTH = 4,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_writeback_if.slave bus
);
    localparam int NREG = 1 << ADDR;
    localparam int PW   = $clog2(QDEPTH);
    localparam int CW   = PW + 1;
    localparam int SW   = $clog2(STARVE + 1);
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);
    localparam logic [SW-1:0] SLIM = SW'(STARVE);

    typedef struct packed {
        logic [ADDR-1:0] addr;
        logic [BITS-1:0] dat;
    } entry_t;

    entry_t          mem_q [QDEPTH];
    entry_t          mem_d [QDEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            write_q, write_d;
    logic [ADDR-1:0] dest_addr_q, dest_addr_d;
    logic [BITS-1:0] dest_data_q, dest_data_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            ld_ready, alu_ready;
    logic            push, grant_alu, grant_ld, fifo_empty;
    logic [NREG-1:0] set_mask, clr_mask;
    entry_t          head;

    // Both readies come from registered state only, so they never depend on this cycle's valids.
    assign fifo_empty = (count_q == '0);
    assign ld_ready   = (count_q != FULL);
    assign alu_ready  = (starve_q != SLIM);
    assign head       = mem_q[rd_ptr_q];

    assign push      = bus.ld_valid && ld_ready;
    assign grant_alu = bus.alu_valid && alu_ready;
    assign grant_ld  = !grant_alu && !fifo_empty;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        write_d     = 1'b0;
        dest_addr_d = dest_addr_q;
        dest_data_d = dest_data_q;
        set_mask    = '0;
        clr_mask    = '0;
        starve_d    = starve_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{addr: bus.ld_addr, dat: bus.ld_data};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end

        if (grant_alu) begin
            write_d               = 1'b1;
            dest_addr_d           = bus.alu_addr;
            dest_data_d           = bus.alu_data;
            clr_mask[bus.alu_addr] = 1'b1;
        end else if (grant_ld) begin
            write_d             = 1'b1;
            dest_addr_d         = head.addr;
            dest_data_d         = head.dat;
            clr_mask[head.addr] = 1'b1;
            rd_ptr_d            = rd_ptr_q + PW'(1);
        end

        // A new issue to the register being written this cycle must stay pending.
        if (bus.issue_valid) begin
            set_mask[bus.issue_addr] = 1'b1;
        end
        busy_d = (busy_q & ~clr_mask) | set_mask;

        if (grant_ld || fifo_empty) begin
            starve_d = '0;
        end else if (grant_alu) begin
            starve_d = starve_q + SW'(1);
        end

        count_d = count_q + CW'(push) - CW'(grant_ld);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            write_q     <= 1'b0;
            dest_addr_q <= '0;
            dest_data_q <= '0;
            busy_q      <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            write_q     <= write_d;
            dest_addr_q <= dest_addr_d;
            dest_data_q <= dest_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ld_ready   = ld_ready;
    assign bus.alu_ready  = alu_ready;
    assign bus.Write      = write_q;
    assign bus.DestAddr   = dest_addr_q;
    assign bus.DestData   = dest_data_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus a cycle model whose load queue acts as the scoreboard.
module tb_regfile_writeback;
    localparam int BITS = 16, ADDR = 2, QDEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [1:0]  issue_addr = '0;
    logic        alu_valid = 1'b0;
    logic [1:0]  alu_addr = '0;
    logic [15:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic [1:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    bit          sel = 1'b0;
    int          checks = 0;
    int          errors = 0;

    regfile_writeback_if #(.BITS(BITS), .ADDR(ADDR), .QDEPTH(QDEPTH)) ba ();
    regfile_writeback_if #(.BITS(BITS), .ADDR(ADDR), .QDEPTH(QDEPTH)) bf ();

    assign ba.issue_valid = issue_valid;  assign bf.issue_valid = issue_valid;
    assign ba.issue_addr  = issue_addr;   assign bf.issue_addr  = issue_addr;
    assign ba.alu_valid   = alu_valid;    assign bf.alu_valid   = alu_valid;
    assign ba.alu_addr    = alu_addr;     assign bf.alu_addr    = alu_addr;
    assign ba.alu_data    = alu_data;     assign bf.alu_data    = alu_data;
    assign ba.ld_valid    = ld_valid;     assign bf.ld_valid    = ld_valid;
    assign ba.ld_addr     = ld_addr;      assign bf.ld_addr     = ld_addr;
    assign ba.ld_data     = ld_data;      assign bf.ld_data     = ld_data;

    regfile_writeback #(.BITS(BITS), .ADDR(ADDR), .QDEPTH(QDEPTH), .STARVE(4))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ba.slave));
    regfile_writeback #(.BITS(BITS), .ADDR(ADDR), .QDEPTH(QDEPTH), .STARVE(16))
        dut_f (.clk(clk), .rst_n(rst_n), .bus(bf.slave));

    // sel picks which instance the checks observe: 0 -> STARVE=4, 1 -> STARVE=16.
    logic        mon_write, mon_ldr, mon_alur;
    logic [1:0]  mon_addr;
    logic [15:0] mon_data;
    logic [3:0]  mon_busy;
    logic [2:0]  mon_cnt;
    assign mon_write = sel ? bf.Write      : ba.Write;
    assign mon_ldr   = sel ? bf.ld_ready   : ba.ld_ready;
    assign mon_alur  = sel ? bf.alu_ready  : ba.alu_ready;
    assign mon_addr  = sel ? bf.DestAddr   : ba.DestAddr;
    assign mon_data  = sel ? bf.DestData   : ba.DestData;
    assign mon_busy  = sel ? bf.busy       : ba.busy;
    assign mon_cnt   = sel ? bf.fifo_count : ba.fifo_count;

    // Cycle model: at each falling edge compare against the model, then advance it with the inputs for the next edge.
    logic        m_w;
    logic [1:0]  m_addr;
    logic [15:0] m_data;
    logic [3:0]  m_busy;
    logic [2:0]  m_count;
    int          m_starve;
    logic [17:0] m_q[$];

    initial begin
        logic [17:0] e;
        bit ga, gl, pu;
        int lim;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_w = 0; m_addr = '0; m_data = '0; m_busy = '0; m_count = '0; m_starve = 0;
                m_q.delete();
            end else begin
                checks++; if (mon_write !== m_w) begin errors++; $display("FAIL mdl_write got=%b want=%b t=%0t", mon_write, m_w, $time); end
                checks++; if (mon_addr !== m_addr) begin errors++; $display("FAIL mdl_addr got=%h want=%h t=%0t", mon_addr, m_addr, $time); end
                checks++; if (mon_data !== m_data) begin errors++; $display("FAIL mdl_data got=%h want=%h t=%0t", mon_data, m_data, $time); end
                checks++; if (mon_busy !== m_busy) begin errors++; $display("FAIL mdl_busy got=%b want=%b t=%0t", mon_busy, m_busy, $time); end
                checks++; if (mon_cnt !== m_count) begin errors++; $display("FAIL mdl_count got=%0d want=%0d t=%0t", mon_cnt, m_count, $time); end
                lim = sel ? 16 : 4;
                checks++; if (mon_ldr !== (m_count != 3'd4)) begin errors++; $display("FAIL mdl_ld_ready got=%b want=%b t=%0t", mon_ldr, (m_count != 3'd4), $time); end
                checks++; if (mon_alur !== (m_starve != lim)) begin errors++; $display("FAIL mdl_alu_ready got=%b want=%b t=%0t", mon_alur, (m_starve != lim), $time); end
                ga = alu_valid && (m_starve != lim);
                gl = !ga && (m_count != 0);
                pu = ld_valid && (m_count != 3'd4);
                if (ga) begin
                    m_w = 1; m_addr = alu_addr; m_data = alu_data; m_busy[alu_addr] = 1'b0;
                end else if (gl) begin
                    e = m_q.pop_front();
                    m_w = 1; m_addr = e[17:16]; m_data = e[15:0]; m_busy[m_addr] = 1'b0;
                end else begin
                    m_w = 0;
                end
                if (issue_valid) m_busy[issue_addr] = 1'b1;
                if (gl || m_count == 0) m_starve = 0;
                else if (ga) m_starve++;
                if (pu) m_q.push_back({ld_addr, ld_data});
                m_count = m_count + 3'(pu) - 3'(gl);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit s);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        issue_valid = 0; alu_valid = 0; ld_valid = 0;
        sel = s;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (mon_write !== 1'b0) begin errors++; $display("FAIL rst_write got=%b want=0", mon_write); end
        checks++; if (mon_addr !== 2'd0) begin errors++; $display("FAIL rst_addr got=%h want=0", mon_addr); end
        checks++; if (mon_data !== 16'h0) begin errors++; $display("FAIL rst_data got=%h want=0", mon_data); end
        checks++; if (mon_busy !== 4'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", mon_busy); end
        checks++; if (mon_cnt !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d want=0", mon_cnt); end
        checks++; if (mon_ldr !== 1'b1 || mon_alur !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b%b want=11", mon_ldr, mon_alur); end
        issue_valid = 1; issue_addr = 2'd1;
        alu_valid = 1; alu_addr = 2'd0; alu_data = 16'h5555;
        ld_valid = 1; ld_addr = 2'd2; ld_data = 16'h1111;
        cyc();
        issue_addr = 2'd3; ld_data = 16'h2222;
        cyc();
        issue_valid = 0; ld_addr = 2'd0; ld_data = 16'h3333;
        cyc();
        ld_valid = 0; alu_valid = 0;
        checks++; if (mon_cnt !== 3'd3) begin errors++; $display("FAIL pre_rst_count got=%0d want=3", mon_cnt); end
        checks++; if (mon_busy !== 4'b1010) begin errors++; $display("FAIL pre_rst_busy got=%b want=1010", mon_busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mon_write !== 1'b0 || mon_data !== 16'h0 || mon_addr !== 2'd0) begin errors++; $display("FAIL mid_rst_port got=%b/%h/%h want=0/0/0", mon_write, mon_addr, mon_data); end
        checks++; if (mon_cnt !== 3'd0 || mon_busy !== 4'b0) begin errors++; $display("FAIL mid_rst_state got=%0d/%b want=0/0000", mon_cnt, mon_busy); end
        checks++; if (mon_ldr !== 1'b1 || mon_alur !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b%b want=11", mon_ldr, mon_alur); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_alu();
        issue_valid = 1; issue_addr = 2'd2;
        cyc();
        issue_valid = 0;
        alu_valid = 1; alu_addr = 2'd2; alu_data = 16'hBEEF;
        checks++; if (mon_busy[2] !== 1'b1) begin errors++; $display("FAIL alu_busy_set got=%b want=1", mon_busy[2]); end
        cyc();
        alu_valid = 0;
        checks++; if (mon_write !== 1'b1 || mon_addr !== 2'd2 || mon_data !== 16'hBEEF) begin errors++; $display("FAIL alu_write got=%b/%h/%h want=1/2/beef", mon_write, mon_addr, mon_data); end
        checks++; if (mon_busy[2] !== 1'b0) begin errors++; $display("FAIL alu_busy_clr got=%b want=0", mon_busy[2]); end
        cyc();
        checks++; if (mon_write !== 1'b0 || mon_data !== 16'hBEEF) begin errors++; $display("FAIL alu_hold got=%b/%h want=0/beef", mon_write, mon_data); end
    endtask

    task automatic test_load();
        ld_valid = 1; ld_addr = 2'd3; ld_data = 16'h1234;
        checks++; if (mon_cnt !== 3'd0) begin errors++; $display("FAIL ld_count0 got=%0d want=0", mon_cnt); end
        cyc();
        ld_valid = 0;
        checks++; if (mon_cnt !== 3'd1 || mon_write !== 1'b0) begin errors++; $display("FAIL ld_stage1 got=%0d/%b want=1/0", mon_cnt, mon_write); end
        cyc();
        checks++; if (mon_write !== 1'b1 || mon_addr !== 2'd3 || mon_data !== 16'h1234) begin errors++; $display("FAIL ld_write got=%b/%h/%h want=1/3/1234", mon_write, mon_addr, mon_data); end
        checks++; if (mon_cnt !== 3'd0) begin errors++; $display("FAIL ld_count2 got=%0d want=0", mon_cnt); end
    endtask

    task automatic test_starve();
        alu_valid = 1; alu_addr = 2'd0; alu_data = 16'hB000;
        ld_valid = 1; ld_addr = 2'd2; ld_data = 16'hC0DE;
        cyc();
        ld_valid = 0;
        checks++; if (mon_cnt !== 3'd1 || mon_alur !== 1'b1 || mon_data !== 16'hB000) begin errors++; $display("FAIL stv_start got=%0d/%b/%h want=1/1/b000", mon_cnt, mon_alur, mon_data); end
        for (int i = 1; i <= 4; i++) begin
            alu_data = 16'hB000 + 16'(i);
            cyc();
            checks++; if (mon_write !== 1'b1 || mon_data !== 16'hB000 + 16'(i)) begin errors++; $display("FAIL stv_alu%0d got=%b/%h want=1/%h", i, mon_write, mon_data, 16'hB000 + 16'(i)); end
        end
        checks++; if (mon_alur !== 1'b0 || mon_cnt !== 3'd1) begin errors++; $display("FAIL stv_block got=%b/%0d want=0/1", mon_alur, mon_cnt); end
        alu_data = 16'hB005;
        cyc();
        checks++; if (mon_addr !== 2'd2 || mon_data !== 16'hC0DE || mon_alur !== 1'b1 || mon_cnt !== 3'd0) begin errors++; $display("FAIL stv_drain got=%h/%h/%b/%0d want=2/c0de/1/0", mon_addr, mon_data, mon_alur, mon_cnt); end
        cyc();
        alu_valid = 0;
        checks++; if (mon_write !== 1'b1 || mon_data !== 16'hB005) begin errors++; $display("FAIL stv_resume got=%b/%h want=1/b005", mon_write, mon_data); end
        cyc();
    endtask

    task automatic test_collision();
        issue_valid = 1; issue_addr = 2'd1;
        alu_valid = 1; alu_addr = 2'd1; alu_data = 16'h7777;
        cyc();
        issue_valid = 0; alu_data = 16'h7778;
        checks++; if (mon_busy[1] !== 1'b1 || mon_write !== 1'b1 || mon_addr !== 2'd1) begin errors++; $display("FAIL coll_set_wins got=%b/%b/%h want=1/1/1", mon_busy[1], mon_write, mon_addr); end
        cyc();
        alu_valid = 0;
        checks++; if (mon_busy[1] !== 1'b0 || mon_data !== 16'h7778) begin errors++; $display("FAIL coll_clear got=%b/%h want=0/7778", mon_busy[1], mon_data); end
        cyc();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_addr  = 2'($urandom);
            alu_valid   = ($urandom_range(0, 2) != 0);
            alu_addr    = 2'($urandom);
            alu_data    = 16'($urandom);
            ld_valid    = 1'($urandom_range(0, 1));
            ld_addr     = 2'($urandom);
            ld_data     = 16'($urandom);
            cyc();
        end
        issue_valid = 0; alu_valid = 0; ld_valid = 0;
        repeat (8) cyc();
        checks++; if (mon_cnt !== 3'd0 || mon_write !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%0d/%b want=0/0", mon_cnt, mon_write); end
    endtask

    task automatic test_fifo_full();
        do_reset(1'b1);
        alu_valid = 1; alu_addr = 2'd0; alu_data = 16'h0F00;
        ld_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ld_addr = 2'(i + 1);
            ld_data = 16'hA001 + 16'(i);
            cyc();
        end
        checks++; if (mon_cnt !== 3'd4 || mon_ldr !== 1'b0) begin errors++; $display("FAIL full_reach got=%0d/%b want=4/0", mon_cnt, mon_ldr); end
        ld_addr = 2'd1; ld_data = 16'hA005;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (mon_cnt !== 3'd4 || mon_ldr !== 1'b0 || mon_data !== 16'h0F00) begin errors++; $display("FAIL full_hold%0d got=%0d/%b/%h want=4/0/0f00", i, mon_cnt, mon_ldr, mon_data); end
        end
        alu_valid = 0;
        cyc();
        checks++; if (mon_write !== 1'b1 || mon_data !== 16'hA001 || mon_cnt !== 3'd3 || mon_ldr !== 1'b1) begin errors++; $display("FAIL full_pop1 got=%b/%h/%0d/%b want=1/a001/3/1", mon_write, mon_data, mon_cnt, mon_ldr); end
        cyc();
        ld_valid = 0;
        checks++; if (mon_data !== 16'hA002 || mon_cnt !== 3'd3) begin errors++; $display("FAIL full_pop2 got=%h/%0d want=a002/3", mon_data, mon_cnt); end
        for (int i = 3; i <= 5; i++) begin
            cyc();
            checks++; if (mon_write !== 1'b1 || mon_data !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL full_order%0d got=%b/%h want=1/%h", i, mon_write, mon_data, 16'hA000 + 16'(i)); end
        end
        cyc();
        checks++; if (mon_write !== 1'b0 || mon_cnt !== 3'd0) begin errors++; $display("FAIL full_empty got=%b/%0d want=0/0", mon_write, mon_cnt); end
    endtask

    initial begin
        do_reset(1'b0);
        test_reset();
        test_alu();
        test_load();
        test_starve();
        test_collision();
        test_back_to_back();
        test_fifo_full();
        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
